// File: rtl/sram_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_frame_ctrl
// Purpose  : Capture/playback sequencer for a 256Kx8 async SRAM frame buffer.
//            Optional continuous playback loop: SRAM_FRAME_PB_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_frame_ctrl #(
    parameter int FRAME_WORDS = 38400,
    parameter int WE_CYC      = 2,
    parameter int RD_CYC      = 2
) (
    input  logic        FPGA_clk,
    input  logic        rst_n,
    input  logic        cap_start,
    input  logic        pb_start,
    input  logic        stop,
    input  logic        vsync,
    input  logic        wr_req,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    input  logic        rd_req,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [17:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    input  logic [7:0]  sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_cs_n,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        busy,
    output logic        frame_done,
    output logic [17:0] frame_len
);

    localparam int c_CNT_MAX = (WE_CYC > RD_CYC) ? WE_CYC : RD_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_WE_LAST = c_CNT_W'(WE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(RD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [17:0]        c_FRAME_LEN = 18'(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAP_WAIT = 2'd1,
        ST_CAP_RUN  = 2'd2,
        ST_PB_RUN   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        EN_IDLE    = 3'd0,
        EN_WR_A    = 3'd1,
        EN_WR_LOW  = 3'd2,
        EN_WR_HOLD = 3'd3,
        EN_RD      = 3'd4
    } eng_t;

    state_t               r_state, w_state_nxt;
    eng_t                 r_eng, w_eng_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [17:0]          r_addr, w_addr_nxt;
    logic [7:0]           r_dq_o, w_dq_o_nxt;
    logic [17:0]          r_frame_len, w_frame_len_nxt;
    logic                 r_vs_pend, w_vs_pend_nxt;
    logic                 r_stop_pend, w_stop_pend_nxt;
    logic                 r_vsync_d;
    logic [7:0]           r_rd_data;
    logic                 r_rd_valid, r_frame_done;
    logic                 r_we_n, r_oe_n, r_cs_n, r_dq_oe, r_busy;
    logic                 w_rd_sample, w_done, w_wr_ack;
    logic                 w_vs_rise, w_eng_idle, w_stop_now;
    logic [17:0]          w_addr_inc;

    assign w_vs_rise  = vsync & ~r_vsync_d;
    assign w_eng_idle = (r_eng == EN_IDLE);
    assign w_stop_now = stop | r_stop_pend;
    assign w_addr_inc = r_addr + 18'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_eng_nxt       = r_eng;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = r_addr;
        w_dq_o_nxt      = r_dq_o;
        w_frame_len_nxt = r_frame_len;
        w_vs_pend_nxt   = r_vs_pend;
        w_stop_pend_nxt = r_stop_pend | ((r_state != ST_IDLE) & stop);
        w_rd_sample     = 1'b0;
        w_done          = 1'b0;
        w_wr_ack        = 1'b0;

        // Access engine: an access always runs to completion once accepted.
        case (r_eng)
            EN_WR_A: begin
                w_eng_nxt = EN_WR_LOW;
                w_cnt_nxt = '0;
            end
            EN_WR_LOW: begin
                if (r_cnt == c_WE_LAST) begin
                    w_eng_nxt = EN_WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            EN_WR_HOLD: begin
                w_eng_nxt  = EN_IDLE;
                w_addr_nxt = w_addr_inc;
            end
            EN_RD: begin
                if (r_cnt == c_RD_LAST) begin
                    w_eng_nxt   = EN_IDLE;
                    w_rd_sample = 1'b1;
                    if (w_addr_inc == r_frame_len) begin
`ifdef SRAM_FRAME_PB_LOOP_EN
                        w_addr_nxt = '0;
`else
                        w_addr_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
`endif
                    end else begin
                        w_addr_nxt = w_addr_inc;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: ;
        endcase

        case (r_state)
            ST_IDLE: begin
                w_stop_pend_nxt = 1'b0;
                w_vs_pend_nxt   = 1'b0;
                if (cap_start) begin
                    w_state_nxt = ST_CAP_WAIT;
                    w_addr_nxt  = '0;
                end else if (pb_start && (r_frame_len != '0)) begin
                    w_state_nxt = ST_PB_RUN;
                    w_addr_nxt  = '0;
                end
            end
            ST_CAP_WAIT: begin
                if (w_stop_now) begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_len_nxt = r_addr;
                end else if (w_vs_rise) begin
                    w_state_nxt = ST_CAP_RUN;
                end
            end
            ST_CAP_RUN: begin
                if (w_vs_rise) begin
                    w_vs_pend_nxt = 1'b1;
                end
                // r_addr doubles as the count of completed writes.
                if (w_eng_idle) begin
                    if (w_stop_now) begin
                        w_state_nxt     = ST_IDLE;
                        w_frame_len_nxt = r_addr;
                    end else if (r_vs_pend || w_vs_rise || (r_addr == c_FRAME_LEN)) begin
                        w_state_nxt     = ST_IDLE;
                        w_frame_len_nxt = r_addr;
                        w_done          = 1'b1;
                    end else if (wr_req) begin
                        w_wr_ack   = 1'b1;
                        w_dq_o_nxt = wr_data;
                        w_eng_nxt  = EN_WR_A;
                    end
                end
            end
            ST_PB_RUN: begin
`ifdef SRAM_FRAME_PB_LOOP_EN
                if (w_vs_rise) begin
                    w_vs_pend_nxt = 1'b1;
                end
                if (w_eng_idle) begin
                    if (w_stop_now) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_vs_pend || w_vs_rise) begin
                        w_addr_nxt    = '0;
                        w_vs_pend_nxt = 1'b0;
                    end else if (rd_req) begin
                        w_eng_nxt = EN_RD;
                        w_cnt_nxt = '0;
                    end
                end
`else
                if (w_eng_idle) begin
                    if (w_stop_now) begin
                        w_state_nxt = ST_IDLE;
                    end else if (rd_req) begin
                        w_eng_nxt = EN_RD;
                        w_cnt_nxt = '0;
                    end
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from next-state values so they never glitch.
    always_ff @(posedge FPGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_eng        <= EN_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_dq_o       <= '0;
            r_frame_len  <= '0;
            r_vs_pend    <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_vsync_d    <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_cs_n       <= 1'b1;
            r_dq_oe      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_eng        <= w_eng_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_dq_o       <= w_dq_o_nxt;
            r_frame_len  <= w_frame_len_nxt;
            r_vs_pend    <= w_vs_pend_nxt;
            r_stop_pend  <= w_stop_pend_nxt;
            r_vsync_d    <= vsync;
            r_rd_valid   <= w_rd_sample;
            r_frame_done <= w_done;
            if (w_rd_sample) begin
                r_rd_data <= sram_dq_i;
            end
            r_we_n  <= (w_eng_nxt != EN_WR_LOW);
            r_dq_oe <= (w_eng_nxt == EN_WR_A) || (w_eng_nxt == EN_WR_LOW) ||
                       (w_eng_nxt == EN_WR_HOLD);
            r_oe_n  <= (w_state_nxt != ST_PB_RUN);
            r_cs_n  <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign wr_ack     = w_wr_ack;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_cs_n  = r_cs_n;
    assign sram_we_n  = r_we_n;
    assign sram_oe_n  = r_oe_n;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign frame_len  = r_frame_len;

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_frame_ctrl
// Purpose  : Self-checking bench with an SRAM memory model and a byte-queue
//            frame reference for sram_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_frame_ctrl;

    localparam int c_FRAME_WORDS = 300;
    localparam int c_WE_CYC      = 2;
    localparam int c_RD_CYC      = 2;
    localparam int c_SHORT_LEN   = 100;

    logic        FPGA_clk = 1'b0;
    logic        rst_n;
    logic        cap_start, pb_start, stop, vsync;
    logic        wr_req;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [17:0] sram_addr;
    logic [7:0]  sram_dq_o;
    logic [7:0]  sram_dq_i;
    logic        sram_dq_oe, sram_cs_n, sram_we_n, sram_oe_n;
    logic        busy, frame_done;
    logic [17:0] frame_len;

    always #5 FPGA_clk = ~FPGA_clk;

    sram_frame_ctrl #(
        .FRAME_WORDS (c_FRAME_WORDS),
        .WE_CYC      (c_WE_CYC),
        .RD_CYC      (c_RD_CYC)
    ) dut (
        .FPGA_clk   (FPGA_clk),
        .rst_n      (rst_n),
        .cap_start  (cap_start),
        .pb_start   (pb_start),
        .stop       (stop),
        .vsync      (vsync),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_cs_n  (sram_cs_n),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_len  (frame_len)
    );

    // Behavioural async SRAM: a byte is stored when a WE pulse ends.
    logic [7:0] mem [0:262143];
    assign sram_dq_i = (!sram_oe_n && !sram_cs_n) ? mem[sram_addr] : 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int we_pulses, we_bad_len, stab_bad, low_run;
    logic        prev_we_n = 1'b1;
    logic [17:0] prev_addr = '0;
    logic [7:0]  prev_dq   = '0;
    logic [17:0] last_wr_addr = '0;
    logic [7:0]  exp_q [$];

    logic        s_wr_ack, s_rd_valid, s_frame_done, s_busy;
    logic        s_we_n, s_oe_n, s_cs_n, s_dq_oe;
    logic [7:0]  s_rd_data, s_dq_o;
    logic [17:0] s_addr, s_frame_len;

    // Samples one cycle mid-period, updates the SRAM model, then moves to the next cycle.
    task automatic step();
        @(negedge FPGA_clk);
        s_wr_ack     = wr_ack;
        s_rd_valid   = rd_valid;
        s_frame_done = frame_done;
        s_busy       = busy;
        s_we_n       = sram_we_n;
        s_oe_n       = sram_oe_n;
        s_cs_n       = sram_cs_n;
        s_dq_oe      = sram_dq_oe;
        s_rd_data    = rd_data;
        s_dq_o       = sram_dq_o;
        s_addr       = sram_addr;
        s_frame_len  = frame_len;
        if (!s_we_n) begin
            low_run++;
            if (s_addr !== prev_addr || s_dq_o !== prev_dq || !s_dq_oe) stab_bad++;
        end else if (!prev_we_n) begin
            if (low_run != c_WE_CYC) we_bad_len++;
            if (s_addr !== prev_addr || s_dq_o !== prev_dq || !s_dq_oe) stab_bad++;
            if (!s_cs_n) begin
                mem[prev_addr] = prev_dq;
                last_wr_addr   = prev_addr;
            end
            we_pulses++;
            low_run = 0;
        end
        prev_we_n = s_we_n;
        prev_addr = s_addr;
        prev_dq   = s_dq_o;
        cyc++;
        @(posedge FPGA_clk);
        #1;
    endtask

    task automatic clear_stats();
        we_pulses  = 0;
        we_bad_len = 0;
        stab_bad   = 0;
        low_run    = 0;
    endtask

    // Capture stimulus only; the calling test judges the collected results.
    task automatic run_capture(input int n, input bit end_by_vsync,
                               output int pre_acks, output int acks, output int extra,
                               output int done_cnt, output int min_gap, output bit timed_out);
        int last_ack;
        int k;
        exp_q.delete();
        clear_stats();
        pre_acks = 0; acks = 0; extra = 0; done_cnt = 0; min_gap = 1000; last_ack = -1000;
        cap_start = 1'b1;
        step();
        cap_start = 1'b0;
        wr_req  = 1'b1;
        wr_data = 8'hFF;
        repeat (4) begin
            step();
            if (s_wr_ack) pre_acks++;
        end
        vsync = 1'b1;
        step();
        if (s_wr_ack) pre_acks++;
        vsync = 1'b0;
        k = 0;
        while (acks < n && k < n * (c_WE_CYC + 3) + 50) begin
            step();
            k++;
            if (s_frame_done) done_cnt++;
            if (s_wr_ack) begin
                exp_q.push_back(wr_data);
                if (cyc - last_ack < min_gap) min_gap = cyc - last_ack;
                last_ack = cyc;
                acks++;
                wr_data = (acks == 1) ? 8'h00 : (acks == 2) ? 8'hA5 : 8'($urandom);
            end
        end
        if (end_by_vsync) begin
            wr_req = 1'b0;
            vsync  = 1'b1;
            step();
            vsync  = 1'b0;
            if (s_frame_done) done_cnt++;
            if (s_wr_ack) extra++;
        end
        k = 0;
        while (s_busy && k < 60) begin
            step();
            k++;
            if (s_frame_done) done_cnt++;
            if (s_wr_ack) extra++;
        end
        wr_req = 1'b0;
        timed_out = s_busy;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge FPGA_clk);
        #1;
        n_checks++;
        if ({sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b expected 1110", {sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe});
        end
        n_checks++;
        if ({wr_ack, rd_valid, busy, frame_done} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 0000", {wr_ack, rd_valid, busy, frame_done});
        end
        n_checks++;
        if ({sram_addr, frame_len, sram_dq_o, rd_data} !== 52'd0) begin
            n_errors++;
            $display("FAIL reset_values: addr=%0d len=%0d dq=%h rd=%h expected all 0", sram_addr, frame_len, sram_dq_o, rd_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_pb_no_frame();
        int busy_seen = 0;
        pb_start = 1'b1;
        step();
        pb_start = 1'b0;
        repeat (4) begin
            step();
            if (s_busy) busy_seen++;
        end
        n_checks++;
        if (busy_seen != 0) begin
            n_errors++;
            $display("FAIL pb_no_frame: busy cycles=%0d expected 0", busy_seen);
        end
    endtask

    task automatic test_capture_full();
        int pre_acks, acks, extra, done_cnt, min_gap, bad;
        bit timed_out;
        run_capture(c_FRAME_WORDS, 1'b0, pre_acks, acks, extra, done_cnt, min_gap, timed_out);
        n_checks++;
        if (acks != c_FRAME_WORDS || extra != 0 || pre_acks != 0) begin
            n_errors++;
            $display("FAIL full_acks: acks=%0d extra=%0d pre=%0d expected %0d/0/0", acks, extra, pre_acks, c_FRAME_WORDS);
        end
        n_checks++;
        if (done_cnt != 1 || timed_out) begin
            n_errors++;
            $display("FAIL full_done: pulses=%0d timed_out=%0d expected 1/0", done_cnt, timed_out);
        end
        n_checks++;
        if (s_frame_len !== 18'(c_FRAME_WORDS)) begin
            n_errors++;
            $display("FAIL full_len: got %0d expected %0d", s_frame_len, c_FRAME_WORDS);
        end
        n_checks++;
        if (last_wr_addr !== 18'(c_FRAME_WORDS - 1) || we_pulses != c_FRAME_WORDS) begin
            n_errors++;
            $display("FAIL full_last_addr: addr=%0d pulses=%0d expected %0d/%0d", last_wr_addr, we_pulses, c_FRAME_WORDS - 1, c_FRAME_WORDS);
        end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (mem[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0 || we_bad_len != 0 || stab_bad != 0) begin
            n_errors++;
            $display("FAIL full_data: bad bytes=%0d bad pulses=%0d unstable=%0d expected 0", bad, we_bad_len, stab_bad);
        end
    endtask

    task automatic test_capture_short();
        int pre_acks, acks, extra, done_cnt, min_gap, bad;
        bit timed_out;
        run_capture(c_SHORT_LEN, 1'b1, pre_acks, acks, extra, done_cnt, min_gap, timed_out);
        n_checks++;
        if (pre_acks != 0) begin
            n_errors++;
            $display("FAIL cap_wait_ack: got %0d acks before vsync expected 0", pre_acks);
        end
        n_checks++;
        if (acks != c_SHORT_LEN || extra != 0) begin
            n_errors++;
            $display("FAIL short_acks: acks=%0d extra=%0d expected %0d/0", acks, extra, c_SHORT_LEN);
        end
        n_checks++;
        if (we_pulses != c_SHORT_LEN || we_bad_len != 0) begin
            n_errors++;
            $display("FAIL short_we_pulse: pulses=%0d wrong-length=%0d expected %0d/0", we_pulses, we_bad_len, c_SHORT_LEN);
        end
        n_checks++;
        if (stab_bad != 0) begin
            n_errors++;
            $display("FAIL short_stable: unstable cycles=%0d expected 0", stab_bad);
        end
        n_checks++;
        if (min_gap < c_WE_CYC + 3) begin
            n_errors++;
            $display("FAIL short_ack_gap: min gap=%0d expected >=%0d", min_gap, c_WE_CYC + 3);
        end
        n_checks++;
        if (done_cnt != 1 || timed_out) begin
            n_errors++;
            $display("FAIL short_done: pulses=%0d timed_out=%0d expected 1/0", done_cnt, timed_out);
        end
        n_checks++;
        if (s_frame_len !== 18'(c_SHORT_LEN)) begin
            n_errors++;
            $display("FAIL short_len: got %0d expected %0d", s_frame_len, c_SHORT_LEN);
        end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (mem[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0 || exp_q[0] !== 8'hFF || exp_q[2] !== 8'hA5) begin
            n_errors++;
            $display("FAIL short_data: bad bytes=%0d first=%h third=%h expected 0/ff/a5", bad, exp_q[0], exp_q[2]);
        end
    endtask

    task automatic test_playback();
        int reads = 0, done_cnt = 0, gap_bad = 0, data_bad = 0;
        int last_rv = 0, first_lat = -1, start, k = 0, idx, target, late_rv = 0;
`ifdef SRAM_FRAME_PB_LOOP_EN
        target = 2 * c_SHORT_LEN + 50;
`else
        target = c_SHORT_LEN;
`endif
        start = cyc;
        pb_start = 1'b1;
        step();
        pb_start = 1'b0;
        rd_req = 1'b1;
        while (reads < target && k < target * (c_RD_CYC + 1) + 50) begin
            step();
            k++;
            idx = cyc - 1;
            if (s_frame_done) done_cnt++;
            if (s_rd_valid) begin
                if (s_rd_data !== exp_q[reads % c_SHORT_LEN]) data_bad++;
                if (reads == 0) first_lat = idx - start;
                else if (idx - last_rv != c_RD_CYC + 1) gap_bad++;
                last_rv = idx;
                reads++;
            end
        end
        n_checks++;
        if (reads != target || data_bad != 0) begin
            n_errors++;
            $display("FAIL pb_data: reads=%0d bad=%0d expected %0d/0", reads, data_bad, target);
        end
        n_checks++;
        if (gap_bad != 0 || first_lat != c_RD_CYC + 2) begin
            n_errors++;
            $display("FAIL pb_timing: bad gaps=%0d first latency=%0d expected 0/%0d", gap_bad, first_lat, c_RD_CYC + 2);
        end
`ifdef SRAM_FRAME_PB_LOOP_EN
        stop = 1'b1;
        step();
        stop = 1'b0;
        if (s_frame_done) done_cnt++;
        k = 0;
        while (s_busy && k < 20) begin
            step();
            k++;
            if (s_frame_done) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 0 || s_busy) begin
            n_errors++;
            $display("FAIL pb_loop_stop: done pulses=%0d busy=%0d expected 0/0", done_cnt, s_busy);
        end
`else
        repeat (4) begin
            step();
            if (s_frame_done) done_cnt++;
            if (s_rd_valid) late_rv++;
        end
        n_checks++;
        if (done_cnt != 1 || s_busy || late_rv != 0) begin
            n_errors++;
            $display("FAIL pb_end: done pulses=%0d busy=%0d late reads=%0d expected 1/0/0", done_cnt, s_busy, late_rv);
        end
`endif
        rd_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_playback();
        pb_start = 1'b1;
        step();
        pb_start = 1'b0;
        rd_req = 1'b1;
        repeat (13) step();
        @(negedge FPGA_clk);
        #2;
        n_checks++;
        if (sram_oe_n !== 1'b0 || sram_addr == 18'd0) begin
            n_errors++;
            $display("FAIL rst_precond: oe_n=%b addr=%0d expected 0/nonzero", sram_oe_n, sram_addr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe, busy} !== 5'b11100 || sram_addr !== 18'd0) begin
            n_errors++;
            $display("FAIL rst_async: strobes=%b addr=%0d expected 11100/0", {sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe, busy}, sram_addr);
        end
        @(posedge FPGA_clk);
        #1;
        rst_n  = 1'b1;
        rd_req = 1'b0;
        step();
    endtask

    task automatic test_stop_mid_write();
        int k = 0, acks = 0, done_cnt = 0;
        clear_stats();
        cap_start = 1'b1;
        step();
        cap_start = 1'b0;
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        wr_req  = 1'b1;
        wr_data = 8'h3C;
        s_we_n  = 1'b1;
        while (s_we_n && k < 20) begin
            step();
            k++;
            if (s_wr_ack) acks++;
        end
        n_checks++;
        if (s_we_n !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_find_we: we_n=%b expected 0", s_we_n);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        if (s_wr_ack) acks++;
        if (s_frame_done) done_cnt++;
        k = 0;
        while (s_busy && k < 30) begin
            step();
            k++;
            if (s_wr_ack) acks++;
            if (s_frame_done) done_cnt++;
        end
        wr_req = 1'b0;
        step();
        n_checks++;
        if (we_pulses != 1 || we_bad_len != 0 || stab_bad != 0) begin
            n_errors++;
            $display("FAIL stop_pulse: pulses=%0d short=%0d unstable=%0d expected 1/0/0", we_pulses, we_bad_len, stab_bad);
        end
        n_checks++;
        if (done_cnt != 0 || s_busy || acks != 1) begin
            n_errors++;
            $display("FAIL stop_end: done=%0d busy=%0d acks=%0d expected 0/0/1", done_cnt, s_busy, acks);
        end
        n_checks++;
        if (s_frame_len !== 18'd1 || mem[0] !== 8'h3C) begin
            n_errors++;
            $display("FAIL stop_len: len=%0d mem0=%h expected 1/3c", s_frame_len, mem[0]);
        end
    endtask

    task automatic test_both_starts();
        int not_cap = 0, acks = 0;
        cap_start = 1'b1;
        pb_start  = 1'b1;
        step();
        cap_start = 1'b0;
        pb_start  = 1'b0;
        wr_req = 1'b1;
        repeat (4) begin
            step();
            if (!s_busy || !s_oe_n) not_cap++;
            if (s_wr_ack) acks++;
        end
        n_checks++;
        if (not_cap != 0 || acks != 0) begin
            n_errors++;
            $display("FAIL both_starts: non-capture cycles=%0d acks=%0d expected 0/0", not_cap, acks);
        end
        wr_req = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        n_checks++;
        if (s_busy || s_frame_len !== 18'd0) begin
            n_errors++;
            $display("FAIL both_stop: busy=%0d len=%0d expected 0/0", s_busy, s_frame_len);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        cap_start = 1'b0;
        pb_start  = 1'b0;
        stop      = 1'b0;
        vsync     = 1'b0;
        wr_req    = 1'b0;
        wr_data   = 8'h00;
        rd_req    = 1'b0;
        clear_stats();
        test_reset();
        test_pb_no_frame();
        test_capture_full();
        test_capture_short();
        test_playback();
        test_reset_mid_playback();
        test_stop_mid_write();
        test_both_starts();
        test_pb_no_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
